id_ex_hazard_reg: RTL and testbench
===================================

// Module: id_ex_hazard_reg
// PURPOSE
//  ID/EX pipeline register with load-use hazard detection, branch flush and
//  destination-register tracking for the 5-stage pipe. It captures decoded
//  operands/control from ID and inserts bubbles on load-use hazards or flushes.
//  It also carries EX->MEM->WB destination registers, which are the rd/rd2
//  inputs of the forwarding unit.
// PARAMETERS
//  DATA_W   32  operand width
//  CTRL_W   8   opaque EX/MEM/WB control bundle width (passed through)
//  CNT_W    16  width of stall performance counter
// PORTS
//  clk          in   1       clock, all state updates on rising edge
//  rst          in   1       synchronous, active-high reset
//  ext_hold     in   1       memory-system hold: freeze every register
//  flush        in   1       taken branch resolved in EX: kill ID instruction
//  id_valid     in   1       ID holds a real instruction
//  id_rs        in   5       source register 1
//  id_rt        in   5       source register 2
//  id_rd        in   5       destination register
//  id_uses_rt   in   1       instruction reads rt (0 for I-type ALU, loads)
//  id_regwrite  in   1       instruction writes rd
//  id_memread   in   1       instruction is a load
//  id_ctrl      in   CTRL_W  pass-through control
//  id_a, id_b   in   DATA_W  register-file read data
//  stall        out  1       hold PC and IF/ID this cycle (combinational)
//  ex_valid     out  1       EX stage holds a real instruction
//  ex_rs,ex_rt  out  5       EX source regs (to forwarding rs/rt)
//  ex_rd        out  5       EX destination
//  ex_regwrite  out  1       EX writes rd (already qualified by valid)
//  ex_memread   out  1       EX is a load
//  ex_ctrl      out  CTRL_W  EX control
//  ex_a, ex_b   out  DATA_W  EX operands
//  fwd_rd       out  5       MEM-stage dest (forwarding rd); 0 if no write
//  fwd_rd2      out  5       WB-stage dest (forwarding rd2); 0 if no write
//  stall_cnt    out  CNT_W   saturating count of load-use bubbles
// BEHAVIOUR
//  - Reset: all outputs and registers 0 (EX, MEM, WB all empty; stall_cnt=0).
//  - Hazard: lu = ex_valid & ex_memread & ex_regwrite & ex_rd!=0 & id_valid &
//    (ex_rd==id_rs | (id_uses_rt & ex_rd==id_rt)). stall = lu & ~flush.
//    Purely combinational, same cycle.
//  - Priority each edge: rst > ext_hold > flush > lu > advance.
//  - ext_hold=1: every register keeps its value, stall_cnt unchanged, and
//    flush is ignored. Upstream keeps flush high until hold drops.
//  - flush=1: EX <- bubble. MEM <- EX and WB <- MEM as normal.
//  - lu=1: EX <- bubble. MEM/WB advance. stall_cnt += 1, saturating at all-ones.
//    The load leaves EX, so lu clears next cycle: exactly one bubble per
//    hazard, and ID is re-presented unchanged by upstream.
//  - Advance: EX <- ID fields. ex_regwrite=id_regwrite&id_valid and
//    ex_memread=id_memread&id_valid. With id_valid=0, EX becomes a bubble.
//  - Bubble: valid/regwrite/memread/ctrl/rs/rt/rd/a/b all 0.
//  - MEM dest: rd = ex_rd, we = ex_regwrite. WB dest copies MEM.
//  - fwd_rd = mem_we ? mem_rd : 0; fwd_rd2 = wb_we ? wb_rd : 0. Registered,
//    no combinational path from inputs.
//  - Latency: ID->EX 1 cycle, EX->fwd_rd 1 cycle, ->fwd_rd2 2 cycles.
//  - Writes to r0 never cause a hazard (ex_rd!=0 term).
// TESTING
//  1. rst high 2 cycles with random inputs -> all outputs 0, stall=0.
//  2. lw r5 then add r6,r5,r7 (id_rs=5) -> stall=1 one cycle, EX bubble,
//     add enters EX next cycle, stall_cnt=1, fwd_rd=5 then fwd_rd2=5.
//  3. lw r5 then addi rt=5, id_uses_rt=0 -> no stall; lw r0 then use r0 -> no stall.
//  4. Hazard cycle with flush=1 -> stall=0, EX bubble, stall_cnt unchanged.
//  5. ext_hold=1 for 3 cycles mid-hazard, flush=1 -> all outputs frozen;
//     on release, one bubble then normal advance.
//  6. Force stall_cnt to all-ones with 2^CNT_W hazards (CNT_W=4) -> saturates at 15.

Source files
------------

// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with load-use hazard detection, branch flush and
// MEM/WB destination tracking that feeds the forwarding unit.
module id_ex_hazard_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ext_hold,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd,
  input  logic              id_uses_rt,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [DATA_W-1:0] id_a,
  input  logic [DATA_W-1:0] id_b,
  output logic              stall,
  output logic              ex_valid,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_rd,
  output logic              ex_regwrite,
  output logic              ex_memread,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b,
  output logic [4:0]        fwd_rd,
  output logic [4:0]        fwd_rd2,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic       lu;
  logic [4:0] mem_rd;
  logic       mem_we;
  logic [4:0] wb_rd;
  logic       wb_we;

  // A load in EX whose result the ID instruction needs; r0 is never a hazard.
  always_comb begin
    lu = ex_valid && ex_memread && ex_regwrite && (ex_rd != 5'd0) && id_valid &&
         ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
  end

  assign stall = lu && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid    <= 1'b0;
      ex_rs       <= '0;
      ex_rt       <= '0;
      ex_rd       <= '0;
      ex_regwrite <= 1'b0;
      ex_memread  <= 1'b0;
      ex_ctrl     <= '0;
      ex_a        <= '0;
      ex_b        <= '0;
      mem_rd      <= '0;
      mem_we      <= 1'b0;
      wb_rd       <= '0;
      wb_we       <= 1'b0;
    end else if (!ext_hold) begin
      mem_rd <= ex_rd;
      mem_we <= ex_regwrite;
      wb_rd  <= mem_rd;
      wb_we  <= mem_we;
      // Flush and load-use both leave a bubble in EX while MEM/WB drain.
      if (flush || lu) begin
        ex_valid    <= 1'b0;
        ex_rs       <= '0;
        ex_rt       <= '0;
        ex_rd       <= '0;
        ex_regwrite <= 1'b0;
        ex_memread  <= 1'b0;
        ex_ctrl     <= '0;
        ex_a        <= '0;
        ex_b        <= '0;
      end else begin
        ex_valid    <= id_valid;
        ex_rs       <= id_valid ? id_rs : 5'd0;
        ex_rt       <= id_valid ? id_rt : 5'd0;
        ex_rd       <= id_valid ? id_rd : 5'd0;
        ex_regwrite <= id_regwrite && id_valid;
        ex_memread  <= id_memread && id_valid;
        ex_ctrl     <= id_valid ? id_ctrl : '0;
        ex_a        <= id_valid ? id_a : '0;
        ex_b        <= id_valid ? id_b : '0;
      end
    end
  end

  // Counts inserted load-use bubbles only; flushed hazards are not bubbles of ours.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (!ext_hold && lu && !flush && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign fwd_rd  = mem_we ? mem_rd : 5'd0;
  assign fwd_rd2 = wb_we ? wb_rd : 5'd0;

endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// Scoreboard bench for id_ex_hazard_reg: directed instruction vectors push
// hand-computed expectations, a negedge monitor pops and compares.
module tb_id_ex_hazard_reg;

  typedef struct packed {
    logic        v;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        urt;
    logic        rw;
    logic        mr;
    logic [31:0] a;
  } ins_t;

  typedef struct packed {
    logic       stall;
    ins_t       ex;
    logic [4:0] frd;
    logic [4:0] frd2;
    logic [3:0] cnt;
  } exp_t;

  localparam ins_t NOP   = '0;
  localparam ins_t LWA   = '{1'b1, 5'd1, 5'd0, 5'd5,  1'b0, 1'b1, 1'b1, 32'h0000_0100};
  localparam ins_t ADD   = '{1'b1, 5'd5, 5'd7, 5'd6,  1'b1, 1'b1, 1'b0, 32'h0000_0200};
  localparam ins_t LWB   = '{1'b1, 5'd2, 5'd0, 5'd5,  1'b0, 1'b1, 1'b1, 32'h0000_0300};
  localparam ins_t ADDI  = '{1'b1, 5'd3, 5'd5, 5'd5,  1'b0, 1'b1, 1'b0, 32'h0000_0400};
  localparam ins_t LW0   = '{1'b1, 5'd4, 5'd0, 5'd0,  1'b0, 1'b1, 1'b1, 32'h0000_0500};
  localparam ins_t USE0  = '{1'b1, 5'd0, 5'd0, 5'd7,  1'b1, 1'b1, 1'b0, 32'h0000_0600};
  localparam ins_t LW8   = '{1'b1, 5'd1, 5'd0, 5'd8,  1'b0, 1'b1, 1'b1, 32'h0000_0700};
  localparam ins_t SUB8  = '{1'b1, 5'd2, 5'd8, 5'd9,  1'b1, 1'b1, 1'b0, 32'h0000_0800};
  localparam ins_t GHOST = '{1'b0, 5'd5, 5'd5, 5'd5,  1'b1, 1'b1, 1'b1, 32'h0000_5555};
  localparam ins_t LW3   = '{1'b1, 5'd1, 5'd0, 5'd3,  1'b0, 1'b1, 1'b1, 32'h0000_0900};
  localparam ins_t AND3  = '{1'b1, 5'd3, 5'd4, 5'd10, 1'b1, 1'b1, 1'b0, 32'h0000_0A00};
  localparam ins_t LW11  = '{1'b1, 5'd0, 5'd0, 5'd11, 1'b0, 1'b1, 1'b1, 32'h0000_0B00};
  localparam ins_t USE11 = '{1'b1, 5'd1, 5'd11, 5'd12, 1'b1, 1'b1, 1'b0, 32'h0000_0C00};
  localparam ins_t LWL   = '{1'b1, 5'd1, 5'd0, 5'd5,  1'b0, 1'b1, 1'b1, 32'h0000_1000};
  localparam ins_t DEP   = '{1'b1, 5'd5, 5'd2, 5'd6,  1'b1, 1'b1, 1'b0, 32'h0000_2000};

  logic        clk = 1'b0;
  logic        rst, ext_hold, flush, id_valid, id_uses_rt, id_regwrite, id_memread;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [7:0]  id_ctrl;
  logic [31:0] id_a, id_b;
  logic        stall, ex_valid, ex_regwrite, ex_memread;
  logic [4:0]  ex_rs, ex_rt, ex_rd, fwd_rd, fwd_rd2;
  logic [7:0]  ex_ctrl;
  logic [31:0] ex_a, ex_b;
  logic [3:0]  stall_cnt;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  id_ex_hazard_reg #(.DATA_W(32), .CTRL_W(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .ext_hold(ext_hold), .flush(flush), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_uses_rt(id_uses_rt),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .id_ctrl(id_ctrl),
    .id_a(id_a), .id_b(id_b), .stall(stall), .ex_valid(ex_valid), .ex_rs(ex_rs),
    .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_ctrl(ex_ctrl), .ex_a(ex_a), .ex_b(ex_b), .fwd_rd(fwd_rd), .fwd_rd2(fwd_rd2),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic st, input ins_t ex, input logic [4:0] frd,
                              input logic [4:0] frd2, input logic [3:0] cnt);
    exp_t e;
    e.stall = st;
    e.ex    = ex;
    e.frd   = frd;
    e.frd2  = frd2;
    e.cnt   = cnt;
    return e;
  endfunction

  function automatic ins_t rndIns();
    ins_t i;
    i = ins_t'({$urandom, $urandom});
    return i;
  endfunction

  task automatic drive(input logic r, input logic h, input logic f, input ins_t id);
    rst         = r;
    ext_hold    = h;
    flush       = f;
    id_valid    = id.v;
    id_rs       = id.rs;
    id_rt       = id.rt;
    id_rd       = id.rd;
    id_uses_rt  = id.urt;
    id_regwrite = id.rw;
    id_memread  = id.mr;
    id_a        = id.a;
    id_b        = {id.a[15:0], id.a[31:16]};
    id_ctrl     = id.a[15:8];
  endtask

  // One cycle of stimulus; its expected outputs are queued for the monitor.
  task automatic applyStimulus(input logic r, input logic h, input logic f, input ins_t id,
                               input exp_t e);
    @(posedge clk);
    #1;
    drive(r, h, f, id);
    sb.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    chk("stall", 32'(stall), 32'(e.stall));
    chk("ex_valid", 32'(ex_valid), 32'(e.ex.v));
    chk("ex_rs", 32'(ex_rs), 32'(e.ex.rs));
    chk("ex_rt", 32'(ex_rt), 32'(e.ex.rt));
    chk("ex_rd", 32'(ex_rd), 32'(e.ex.rd));
    chk("ex_regwrite", 32'(ex_regwrite), 32'(e.ex.rw));
    chk("ex_memread", 32'(ex_memread), 32'(e.ex.mr));
    chk("ex_a", ex_a, e.ex.a);
    chk("ex_b", ex_b, {e.ex.a[15:0], e.ex.a[31:16]});
    chk("ex_ctrl", 32'(ex_ctrl), 32'(e.ex.a[15:8]));
    chk("fwd_rd", 32'(fwd_rd), 32'(e.frd));
    chk("fwd_rd2", 32'(fwd_rd2), 32'(e.frd2));
    chk("stall_cnt", 32'(stall_cnt), 32'(e.cnt));
  endtask

  // Monitor: the DUT presents a full output set every cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) checkOutput(sb.pop_front());
  end

  initial begin
    int c0, c1;
    logic [4:0] p;
    drive(1'b1, 1'b0, 1'b0, rndIns());
    // Reset with garbage on the inputs
    applyStimulus(1'b1, 1'b0, 1'b0, rndIns(), mk(0, NOP, 0, 0, 0));
    applyStimulus(1'b1, 1'($urandom_range(1)), 1'($urandom_range(1)), rndIns(), mk(0, NOP, 0, 0, 0));
    // Load-use on rs: one bubble, then the add enters EX
    applyStimulus(0, 0, 0, LWA,  mk(0, NOP,  0, 0, 0));
    applyStimulus(0, 0, 0, ADD,  mk(1, LWA,  0, 0, 0));
    applyStimulus(0, 0, 0, ADD,  mk(0, NOP,  5, 0, 1));
    applyStimulus(0, 0, 0, NOP,  mk(0, ADD,  0, 5, 1));
    // No hazard: rt unused, and r0 destination
    applyStimulus(0, 0, 0, LWB,  mk(0, NOP,  6, 0, 1));
    applyStimulus(0, 0, 0, ADDI, mk(0, LWB,  0, 6, 1));
    applyStimulus(0, 0, 0, LW0,  mk(0, ADDI, 5, 0, 1));
    applyStimulus(0, 0, 0, USE0, mk(0, LW0,  5, 5, 1));
    // Hazard on rt masked by flush; then an invalid ID slot must bubble
    applyStimulus(0, 0, 0, LW8,   mk(0, USE0, 0, 5, 1));
    applyStimulus(0, 0, 1, SUB8,  mk(0, LW8,  7, 0, 1));
    applyStimulus(0, 0, 0, GHOST, mk(0, NOP,  8, 7, 1));
    // Hold with flush pending mid-hazard
    applyStimulus(0, 0, 0, LW3,  mk(0, NOP, 0, 8, 1));
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 1, AND3, mk(0, LW3, 0, 0, 1));
    applyStimulus(0, 0, 1, AND3, mk(0, LW3, 0, 0, 1));
    applyStimulus(0, 0, 0, AND3, mk(0, NOP, 3, 0, 1));
    // Hold during a live stall must not count
    applyStimulus(0, 0, 0, LW11,  mk(0, AND3,  0, 3, 1));
    applyStimulus(0, 1, 0, USE11, mk(1, LW11, 10, 0, 1));
    applyStimulus(0, 0, 0, USE11, mk(1, LW11, 10, 0, 1));
    applyStimulus(0, 0, 0, USE11, mk(0, NOP,  11, 10, 2));
    applyStimulus(0, 0, 0, NOP,   mk(0, USE11, 0, 11, 2));
    applyStimulus(0, 0, 0, NOP,   mk(0, NOP,  12, 0, 2));
    applyStimulus(0, 0, 0, NOP,   mk(0, NOP,   0, 12, 2));
    // Drive the 4-bit counter past saturation
    for (int k = 0; k < 16; k++) begin
      c0 = (2 + k > 15) ? 15 : 2 + k;
      c1 = (3 + k > 15) ? 15 : 3 + k;
      p  = (k == 0) ? 5'd0 : 5'd6;
      applyStimulus(0, 0, 0, LWL, mk(0, NOP, p, 0, 4'(c0)));
      applyStimulus(0, 0, 0, DEP, mk(1, LWL, 0, p, 4'(c0)));
      applyStimulus(0, 0, 0, DEP, mk(0, NOP, 5, 0, 4'(c1)));
      applyStimulus(0, 0, 0, NOP, mk(0, DEP, 0, 5, 4'(c1)));
    end
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain got %0d pending expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
